// File: rtl/learn_key_frontend_if.sv
// learn_key_frontend_if
// Bundles the key front end signals so the scorer side and the bench can
// connect with a single port.
//   key_in        : raw note keys, bit i = note i+1 (driven by master)
//   key_stable    : debounced key vector
//   note_code     : lowest pressed note 1..7, 0 = none
//   multi_key     : more than one debounced key down
//   press_pulse   : one-cycle strobe on a new nonzero note
//   release_pulse : one-cycle strobe when the previous nonzero note ends
//   hold_cycles   : cycles the current or last note has been held
// Modports: master drives key_in and observes the rest; slave is the front end.
interface learn_key_frontend_if #(
   parameter int HOLD_W = 32
) ();
   logic [6:0]        key_in;
   logic [6:0]        key_stable;
   logic [3:0]        note_code;
   logic              multi_key;
   logic              press_pulse;
   logic              release_pulse;
   logic [HOLD_W-1:0] hold_cycles;

   modport master (
      output key_in,
      input  key_stable, note_code, multi_key, press_pulse, release_pulse, hold_cycles
   );

   modport slave (
      input  key_in,
      output key_stable, note_code, multi_key, press_pulse, release_pulse, hold_cycles
   );
endinterface

// File: rtl/learn_key_frontend.sv
// learn_key_frontend
// Debounces the seven note keys, encodes the lowest pressed key into a note
// code and produces press/release strobes plus a saturating hold counter for
// the learning-play scorer.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : learn_key_frontend_if.slave (key_in in; key_stable, note_code,
//           multi_key, press_pulse, release_pulse, hold_cycles out)
// Parameters: DEBOUNCE_CYCLES (>= 2), CNT_W (2**CNT_W > DEBOUNCE_CYCLES), HOLD_W.
// Build option: define LEARN_KEY_SYNC_EN to put a 2-flop synchronizer in front
// of the debouncer (adds 2 edges of latency). Without it key_in must already
// be synchronous to clk.
module learn_key_frontend #(
   parameter int DEBOUNCE_CYCLES = 200000,
   parameter int CNT_W           = 18,
   parameter int HOLD_W          = 32
) (
   input logic            clk,
   input logic            reset,
   learn_key_frontend_if.slave bus
);

   typedef enum logic {IDLE, HELD} state_t;

   logic [6:0]        samp;
   logic [6:0]        samp_prev;
   logic [6:0]        key_stable_q;
   logic [CNT_W-1:0]  db_cnt;
   logic              accept;
   logic [3:0]        next_code;
   logic              next_multi;
   state_t            state;
   logic [3:0]        note_q;
   logic              multi_q;
   logic              press_q;
   logic              release_q;
   logic [HOLD_W-1:0] hold_q;

`ifdef LEARN_KEY_SYNC_EN
   logic [6:0] sync1;
   logic [6:0] sync2;

   // Two-stage synchronizer per key bit; key_in is asynchronous to clk.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= bus.key_in;
         sync2 <= sync1;
      end
   end

   assign samp = sync2;
`else
   assign samp = bus.key_in;
`endif

   // The counter only runs while the sampled pattern is new and unchanged, so
   // reaching DEBOUNCE_CYCLES-2 means this edge is the DEBOUNCE_CYCLES-th
   // consecutive edge with the same differing pattern.
   assign accept = (samp != key_stable_q) && (samp == samp_prev) &&
                   (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 2));

   // Debounce counter and accepted key vector.
   always_ff @(posedge clk) begin
      if (reset) begin
         samp_prev    <= '0;
         db_cnt       <= '0;
         key_stable_q <= '0;
      end else begin
         samp_prev <= samp;
         if ((samp == key_stable_q) || (samp != samp_prev) || accept)
            db_cnt <= '0;
         else
            db_cnt <= db_cnt + 1'b1;
         if (accept)
            key_stable_q <= samp;
      end
   end

   // Encoder on the candidate pattern so note_code and multi_key register at
   // the same edge as key_stable. The loop runs high to low so the lowest set
   // bit wins.
   always_comb begin
      next_code = '0;
      for (int i = 6; i >= 0; i--) begin
         if (samp[i])
            next_code = 4'(i + 1);
      end
      next_multi = ((samp & (samp - 7'd1)) != 7'd0);
   end

   // Note state machine with registered strobes and a saturating hold counter.
   // A rollover (different nonzero note) fires both strobes in one cycle; a key
   // added above the held note keeps the count running without strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         note_q    <= '0;
         multi_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         hold_q    <= '0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         if (accept) begin
            note_q  <= next_code;
            multi_q <= next_multi;
            case (state)
               IDLE: begin
                  if (next_code != 4'd0) begin
                     state   <= HELD;
                     press_q <= 1'b1;
                     hold_q  <= '0;
                  end
               end
               HELD: begin
                  if (next_code == 4'd0) begin
                     state     <= IDLE;
                     release_q <= 1'b1;
                  end else if (next_code != note_q) begin
                     release_q <= 1'b1;
                     press_q   <= 1'b1;
                     hold_q    <= '0;
                  end else if (hold_q != '1) begin
                     hold_q <= hold_q + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if ((state == HELD) && (hold_q != '1)) begin
            hold_q <= hold_q + 1'b1;
         end
      end
   end

   assign bus.key_stable    = key_stable_q;
   assign bus.note_code     = note_q;
   assign bus.multi_key     = multi_q;
   assign bus.press_pulse   = press_q;
   assign bus.release_pulse = release_q;
   assign bus.hold_cycles   = hold_q;

endmodule

// File: tb/tb_learn_key_frontend.sv
// tb_learn_key_frontend
// Self-checking bench for learn_key_frontend with DEBOUNCE_CYCLES=4, HOLD_W=8.
// A table of directed rows walks through press, glitch, release, rollover,
// multi-key, saturation and reset-mid-debounce; every cycle all outputs are
// also compared with a history-window reference model, which then carries a
// randomized phase. Define LEARN_KEY_SYNC_EN for both RTL and bench to cover
// the synchronizer build.
`timescale 1ns/1ps
module tb_learn_key_frontend;

   localparam int DEB      = 4;
   localparam int HOLD_W   = 8;
   localparam int HOLD_MAX = (1 << HOLD_W) - 1;
`ifdef LEARN_KEY_SYNC_EN
   localparam int SYNC_DLY = 2;
`else
   localparam int SYNC_DLY = 0;
`endif
   localparam int LAT = DEB + SYNC_DLY;

   logic clk = 1'b0;
   logic reset;

   learn_key_frontend_if #(.HOLD_W(HOLD_W)) bus ();

   learn_key_frontend #(
      .DEBOUNCE_CYCLES(DEB),
      .CNT_W(4),
      .HOLD_W(HOLD_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: a key pattern is accepted once the last DEB sampled
   // values are all identical and differ from the current stable vector.
   logic [6:0] rawHist[$];
   logic [6:0] sampHist[$];
   logic [6:0] mStable = '0;
   logic [6:0] mS;
   logic [3:0] mNote = '0;
   logic [3:0] mNew;
   logic       mMulti = 1'b0;
   logic       mPress = 1'b0;
   logic       mRel = 1'b0;
   int         mHold = 0;
   bit         mAccept;

   function automatic logic [3:0] lowestNote(logic [6:0] v);
      for (int i = 0; i < 7; i++)
         if (v[i]) return 4'(i + 1);
      return 4'd0;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         rawHist.delete();
         sampHist.delete();
         mStable = '0;
         mNote   = '0;
         mMulti  = 1'b0;
         mPress  = 1'b0;
         mRel    = 1'b0;
         mHold   = 0;
      end else begin
         rawHist.push_back(bus.key_in);
         if (rawHist.size() > 4) void'(rawHist.pop_front());
         mS = (rawHist.size() > SYNC_DLY) ? rawHist[rawHist.size() - 1 - SYNC_DLY] : 7'd0;
         sampHist.push_back(mS);
         if (sampHist.size() > DEB) void'(sampHist.pop_front());
         mAccept = (sampHist.size() == DEB) && (mS != mStable);
         foreach (sampHist[i])
            if (sampHist[i] != mS) mAccept = 1'b0;
         mPress = 1'b0;
         mRel   = 1'b0;
         if (mAccept) begin
            mNew = lowestNote(mS);
            if (mNote != 0 && mNew != mNote) mRel = 1'b1;
            if (mNew != 0 && mNew != mNote) begin
               mPress = 1'b1;
               mHold  = 0;
            end else if (mNote != 0 && mNew != 0) begin
               mHold = (mHold < HOLD_MAX) ? mHold + 1 : HOLD_MAX;
            end
            mNote   = mNew;
            mMulti  = ($countones(mS) > 1);
            mStable = mS;
         end else if (mNote != 0) begin
            mHold = (mHold < HOLD_MAX) ? mHold + 1 : HOLD_MAX;
         end
      end
   end

   task automatic compareField(string name, logic [31:0] actual, logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   // Compares every DUT output with the reference model.
   task automatic checkOutput();
      compareField("key_stable", 32'(bus.key_stable), 32'(mStable));
      compareField("note_code", 32'(bus.note_code), 32'(mNote));
      compareField("multi_key", 32'(bus.multi_key), 32'(mMulti));
      compareField("press_pulse", 32'(bus.press_pulse), 32'(mPress));
      compareField("release_pulse", 32'(bus.release_pulse), 32'(mRel));
      compareField("hold_cycles", 32'(bus.hold_cycles), 32'(mHold));
   endtask

   // Drives inputs at the falling edge, then checks after each rising edge.
   task automatic applyStimulus(logic rst, logic [6:0] key, int cycles);
      reset      = rst;
      bus.key_in = key;
      repeat (cycles) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput();
      end
   endtask

   typedef struct {
      logic       rst;
      logic [6:0] key;
      int         cycles;
      logic [3:0] note;
      logic       press;
      logic       rel;
      logic       multi;
      int         hold;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkVec(logic rst, logic [6:0] key, int cycles, logic [3:0] note,
                                  logic press, logic rel, logic multi, int hold);
      return '{rst, key, cycles, note, press, rel, multi, hold};
   endfunction

   logic [6:0] rKey;
   int         rLen;
   int         rSel;

   initial begin
      reset      = 1'b1;
      bus.key_in = '0;

      // rst, key, cycles, then expected note, press, release, multi, hold at the row's end
      vecs.push_back(mkVec(1, 7'b0000100, 3,       0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 7'b0000100, LAT - 1, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 7'b0000100, 1,       3, 1, 0, 0, 0));
      vecs.push_back(mkVec(0, 7'b0000100, 1,       3, 0, 0, 0, 1));
      vecs.push_back(mkVec(0, 7'b0000000, LAT,     0, 0, 1, 0, LAT));
      vecs.push_back(mkVec(0, 7'b0000000, 2,       0, 0, 0, 0, LAT));
      vecs.push_back(mkVec(0, 7'b0000001, DEB - 1, 0, 0, 0, 0, LAT));
      vecs.push_back(mkVec(0, 7'b0000000, LAT + 2, 0, 0, 0, 0, LAT));
      vecs.push_back(mkVec(0, 7'b0000001, LAT,     1, 1, 0, 0, 0));
      vecs.push_back(mkVec(0, 7'b0000001, 1,       1, 0, 0, 0, 1));
      vecs.push_back(mkVec(0, 7'b0000000, LAT + 1, 0, 0, 0, 0, LAT));
      vecs.push_back(mkVec(0, 7'b0010000, LAT,     5, 1, 0, 0, 0));
      vecs.push_back(mkVec(0, 7'b0010000, 9,       5, 0, 0, 0, 9));
      vecs.push_back(mkVec(0, 7'b0000000, LAT,     0, 0, 1, 0, LAT + 8));
      vecs.push_back(mkVec(0, 7'b0000000, 3,       0, 0, 0, 0, LAT + 8));
      vecs.push_back(mkVec(0, 7'b0000010, LAT + 2, 2, 0, 0, 0, 2));
      vecs.push_back(mkVec(0, 7'b0100000, LAT,     6, 1, 1, 0, 0));
      vecs.push_back(mkVec(0, 7'b0100000, 1,       6, 0, 0, 0, 1));
      vecs.push_back(mkVec(0, 7'b0000100, LAT,     3, 1, 1, 0, 0));
      vecs.push_back(mkVec(0, 7'b1000100, LAT,     3, 0, 0, 1, LAT));
      vecs.push_back(mkVec(0, 7'b1000100, 300,     3, 0, 0, 1, HOLD_MAX));
      vecs.push_back(mkVec(0, 7'b0000001, 2,       3, 0, 0, 1, HOLD_MAX));
      vecs.push_back(mkVec(1, 7'b0000001, 2,       0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 7'b0000001, LAT - 1, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 7'b0000001, 1,       1, 1, 0, 0, 0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].key, vecs[i].cycles);
         compareField($sformatf("row%0d note", i), 32'(bus.note_code), 32'(vecs[i].note));
         compareField($sformatf("row%0d press", i), 32'(bus.press_pulse), 32'(vecs[i].press));
         compareField($sformatf("row%0d release", i), 32'(bus.release_pulse), 32'(vecs[i].rel));
         compareField($sformatf("row%0d multi", i), 32'(bus.multi_key), 32'(vecs[i].multi));
         compareField($sformatf("row%0d hold", i), 32'(bus.hold_cycles), 32'(vecs[i].hold));
      end

      // Randomized phase: short glitches, long holds, rollovers and the odd reset.
      for (int n = 0; n < 200; n++) begin
         rSel = $urandom_range(0, 9);
         if (rSel < 3)
            rKey = 7'd0;
         else if (rSel < 7)
            rKey = 7'(1 << $urandom_range(0, 6));
         else
            rKey = 7'($urandom_range(0, 127));
         rLen = $urandom_range(1, LAT + 4);
         applyStimulus(($urandom_range(0, 40) == 0), rKey, rLen);
      end
      applyStimulus(0, 7'd0, LAT + 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
